// File: rtl/decoder_2x4.sv
// decoder_2x4 -- 2-to-4 line decoder that drives a one-hot select, registered by default.
//   Parameters:
//     ACTIVE_LOW : 1 = the selected Y bit is 0 and the others are 1
//     REG_OUT    : 1 = Y/valid registered (1-cycle latency); 0 = combinational
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous reset, active-high (used only when REG_OUT=1)
//     en    : decode enable; 0 drives Y to the deasserted value and valid to 0
//     A, B  : select, A is the MSB
//     Y     : one-hot decoded select, bit {A,B} asserted
//     valid : Y carries a decoded select
module decoder_2x4 #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       A,
  input  logic       B,
  output logic [3:0] Y,
  output logic       valid
);

  localparam logic [3:0] IDLE = ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [3:0] hot;
  logic       sel_ok;
  logic [3:0] y_next;
  logic       valid_next;

  // An unknown select falls into the default arm, so X/Z on A or B gives
  // the deasserted value instead of passing X on to downstream selects.
  always_comb begin
    hot    = '0;
    sel_ok = 1'b0;
    case ({A, B})
      2'b00:   begin hot = 4'b0001; sel_ok = 1'b1; end
      2'b01:   begin hot = 4'b0010; sel_ok = 1'b1; end
      2'b10:   begin hot = 4'b0100; sel_ok = 1'b1; end
      2'b11:   begin hot = 4'b1000; sel_ok = 1'b1; end
      default: begin hot = '0;      sel_ok = 1'b0; end
    endcase
    if (en == 1'b1 && sel_ok) begin
      valid_next = 1'b1;
      y_next     = ACTIVE_LOW ? ~hot : hot;
    end else begin
      valid_next = 1'b0;
      y_next     = IDLE;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          Y     <= IDLE;
          valid <= 1'b0;
        end else begin
          Y     <= y_next;
          valid <= valid_next;
        end
      end
    end else begin : g_comb
      always_comb begin
        Y     = y_next;
        valid = valid_next;
      end
    end
  endgenerate

endmodule

// File: tb/tb_decoder_2x4.sv
// tb_decoder_2x4 -- bench for decoder_2x4. It drives three instances from the same inputs:
//   u_hi (active-high, registered), u_lo (active-low, registered) and
//   u_cb (active-high, combinational). Expected values come from an
//   arithmetic model: bit number 2*A+B is set, and the result is inverted
//   for active-low.
module tb_decoder_2x4;

  logic clk = 1'b0;
  logic run = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic a   = 1'b0;
  logic b   = 1'b0;

  logic [3:0] y_hi, y_lo, y_cb;
  logic       v_hi, v_lo, v_cb;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  decoder_2x4 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) u_hi (
    .clk(clk), .rst(rst), .en(en), .A(a), .B(b), .Y(y_hi), .valid(v_hi));
  decoder_2x4 #(.ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .A(a), .B(b), .Y(y_lo), .valid(v_lo));
  decoder_2x4 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) u_cb (
    .clk(clk), .rst(rst), .en(en), .A(a), .B(b), .Y(y_cb), .valid(v_cb));

  initial forever begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_y(input bit e, input bit sa, input bit sb, input bit al);
    logic [3:0] v;
    int unsigned idx;
    idx = 2 * int'(sa) + int'(sb);
    v   = e ? 4'(1 << idx) : 4'd0;
    return al ? ~v : v;
  endfunction

  // Drive on negedge, then check the registered outputs just after the next
  // posedge against the inputs sampled at that edge. The combinational
  // instance is checked immediately.
  task automatic step(input bit e, input bit sa, input bit sb);
    @(negedge clk);
    en = e; a = sa; b = sb;
    #1;
    check("cb_y", {4'd0, y_cb}, {4'd0, model_y(e, sa, sb, 1'b0)});
    check("cb_v", {7'd0, v_cb}, {7'd0, e});
    if (v_cb) check("cb_onehot", {7'd0, $onehot(y_cb)}, 8'd1);
    @(posedge clk);
    #1;
    check("hi_y", {4'd0, y_hi}, {4'd0, model_y(e, sa, sb, 1'b0)});
    check("hi_v", {7'd0, v_hi}, {7'd0, e});
    check("lo_y", {4'd0, y_lo}, {4'd0, model_y(e, sa, sb, 1'b1)});
    check("lo_v", {7'd0, v_lo}, {7'd0, e});
  endtask

  initial begin
    // Reset while the clock is stopped, with inputs set to a live select.
    en = 1'b1; a = 1'b1; b = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_hi_y", {4'd0, y_hi}, 8'h00);
    check("rst_hi_v", {7'd0, v_hi}, 8'h00);
    check("rst_lo_y", {4'd0, y_lo}, 8'h0f);
    check("rst_lo_v", {7'd0, v_lo}, 8'h00);
    // The combinational instance ignores rst and follows inputs with no clock.
    check("cb_rst_y", {4'd0, y_cb}, 8'h08);
    a = 1'b0; b = 1'b0;
    #1 check("cb_00", {4'd0, y_cb}, 8'h01);
    a = 1'b1; b = 1'b1;
    #1 check("cb_11", {4'd0, y_cb}, 8'h08);

    // Release reset and step through every select value.
    run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 1, 0);
    step(1, 1, 1);

    // Disable, then enable again.
    step(0, 1, 0);
    step(1, 1, 0);

    // Stream 11 and pulse reset in the middle of a cycle.
    step(1, 1, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_hi_y", {4'd0, y_hi}, 8'h00);
    check("mid_rst_hi_v", {7'd0, v_hi}, 8'h00);
    check("mid_rst_lo_y", {4'd0, y_lo}, 8'h0f);
    check("mid_rst_cb_y", {4'd0, y_cb}, 8'h08);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_hi_y", {4'd0, y_hi}, 8'h08);
    check("post_rst_lo_y", {4'd0, y_lo}, 8'h07);

    // Active-low with select 01.
    step(1, 0, 1);

    // Random sweep.
    for (int i = 0; i < 200; i++) begin
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)));
      if (v_hi) check("hi_onehot", {7'd0, $onehot(y_hi)}, 8'd1);
      if (v_lo) check("lo_onehot", {7'd0, $onehot(~y_lo)}, 8'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
